// File: rtl/axi4mm_pkg.sv
// Shared AXI4 memory-mapped definitions for the write slave, the write master
// and the future read slave: burst encodings, response codes and FSM states.
package axi4mm_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/axi4mm_addr_gen.sv
// Combinational AXI burst address stepper: next byte address (FIXED/INCR/WRAP)
// and the byte-lane mask for the current beat of a possibly narrow transfer.
module axi4mm_addr_gen
    import axi4mm_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int LANES  = 4
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic [2:0]               size,
    input  logic [$clog2(LANES)-1:0] len,
    input  logic [1:0]               burst,
    output logic [ADDR_W-1:0]        next_addr,
    output logic [LANES-1:0]         lane_mask
);
    localparam int LW = $clog2(LANES);

    logic [2:0]        eff_size;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic [LW-1:0]     size_mask;
    logic [LW-1:0]     lane_off;
    logic [LW:0]       lanes_used;

    always_comb begin
        // Oversized beats are flagged as errors upstream; clamp so the math stays bounded.
        eff_size   = (size > 3'(LW)) ? 3'(LW) : size;
        step       = ADDR_W'(1) << eff_size;
        incr_addr  = addr + step;
        wrap_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << eff_size) - ADDR_W'(1);
        size_mask  = LW'((1 << eff_size) - 1);
        lane_off   = addr[LW-1:0] & ~size_mask;
        lanes_used = (LW+1)'(1) << eff_size;

        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = ((incr_addr & wrap_mask) == '0) ? (addr & ~wrap_mask)
                                                                      : incr_addr;
            default:     next_addr = incr_addr;
        endcase

        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (i >= int'(lane_off)) && (i < int'(lane_off) + int'(lanes_used));
        end
    end

endmodule

// File: rtl/axi4mm_write_slave.sv
// AXI4 write slave: one burst at a time, byte-strobed single-cycle writes into
// local memory, one B response per burst (SLVERR is sticky for the burst).
//
// state   | meaning
// IDLE    | awready high, waiting for a write address
// DATA    | wready high, consuming beats until beat count reaches awlen
// RESP    | bvalid high with bid/bresp held until bready
module axi4mm_write_slave
    import axi4mm_pkg::*;
#(
    parameter int DATA_SIZE      = 32,
    parameter int BURST_SIZE     = 8,
    parameter int BURST_LENGTH   = DATA_SIZE / BURST_SIZE,
    parameter int MEMORY_STORAGE = 20
) (
    input  logic                                        aclk,
    input  logic                                        areset,
    input  logic                                        awvalid,
    output logic                                        awready,
    input  logic [$clog2(BURST_LENGTH)-1:0]             awid,
    input  logic [MEMORY_STORAGE-1:0]                   awaddr,
    input  logic [$clog2(BURST_LENGTH)-1:0]             awlen,
    input  logic [2:0]                                  awsize,
    input  logic [1:0]                                  awburst,
    input  logic [DATA_SIZE-1:0]                        wdata,
    input  logic [BURST_LENGTH-1:0]                     wstrb,
    input  logic                                        wlast,
    input  logic                                        wvalid,
    output logic                                        wready,
    output logic [$clog2(BURST_LENGTH)-1:0]             bid,
    output logic [1:0]                                  bresp,
    output logic                                        bvalid,
    input  logic                                        bready,
    output logic                                        mem_we,
    output logic [MEMORY_STORAGE-$clog2(BURST_LENGTH)-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]                        mem_wdata,
    output logic [BURST_LENGTH-1:0]                     mem_wstrb
);
    localparam int LW = $clog2(BURST_LENGTH);

    state_e                    state;
    logic [LW-1:0]             id_q;
    logic [LW-1:0]             len_q;
    logic [LW-1:0]             beat_cnt;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [MEMORY_STORAGE-1:0] addr_q;
    logic                      err_q;
    logic                      aw_bad_q;

    logic [MEMORY_STORAGE-1:0] next_addr;
    logic [BURST_LENGTH-1:0]   lane_mask;
    logic                      aw_illegal;
    logic                      final_beat;
    logic                      last_mismatch;

    axi4mm_addr_gen #(
        .ADDR_W (MEMORY_STORAGE),
        .LANES  (BURST_LENGTH)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .lane_mask (lane_mask)
    );

    always_comb begin
        aw_illegal    = (awburst == BURST_RSVD) || (awsize > 3'(LW)) ||
                        ((awburst == BURST_WRAP) && (awlen != LW'(1)) && (awlen != LW'(3)));
        final_beat    = (beat_cnt == len_q);
        last_mismatch = (wlast != final_beat);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            bid       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            id_q      <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            aw_bad_q  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (awvalid && awready) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        id_q     <= awid;
                        addr_q   <= awaddr;
                        len_q    <= awlen;
                        size_q   <= awsize;
                        burst_q  <= awburst;
                        beat_cnt <= '0;
                        err_q    <= aw_illegal;
                        aw_bad_q <= aw_illegal;
                        state    <= ST_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (wvalid && wready) begin
                        // Illegal AW: beats are drained but memory is never touched.
                        mem_we    <= !aw_bad_q;
                        mem_addr  <= addr_q[MEMORY_STORAGE-1:LW];
                        mem_wdata <= wdata;
                        mem_wstrb <= wstrb & lane_mask;
                        addr_q    <= next_addr;
                        beat_cnt  <= beat_cnt + LW'(1);
                        if (final_beat) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= (err_q || last_mismatch) ? RESP_SLVERR : RESP_OKAY;
                            state  <= ST_RESP;
                        end else if (last_mismatch) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4mm_write_slave.sv
// Scoreboard bench for axi4mm_write_slave: directed bursts push expected
// memory writes and B responses; a negedge monitor pops and compares them.
module tb_axi4mm_write_slave;
    import axi4mm_pkg::*;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [1:0]  awid = '0;
    logic [19:0] awaddr = '0;
    logic [1:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    always #5 aclk = ~aclk;

    axi4mm_write_slave #(
        .DATA_SIZE      (32),
        .BURST_SIZE     (8),
        .BURST_LENGTH   (4),
        .MEMORY_STORAGE (20)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .awvalid   (awvalid),
        .awready   (awready),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    typedef struct {
        logic [17:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        last;
    } wexp_t;

    typedef struct {
        logic [1:0] id;
        logic [1:0] resp;
    } bexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    int    n_vec = 0;
    int    n_err = 0;

    logic [17:0] v_addr[4];
    logic [3:0]  v_strb[4];
    logic [31:0] v_data[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every memory write and every B handshake is matched against the queues.
    always @(negedge aclk) begin
        if (!areset) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    check("mem_addr", mem_addr, e.a);
                    check("mem_wstrb", mem_wstrb, e.s);
                    check("mem_wdata", mem_wdata, e.d);
                    check("bvalid_with_write", bvalid, e.last);
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    check("spurious_bresp", 1, 0);
                end else begin
                    bexp_t b;
                    b = bq.pop_front();
                    check("bid", bid, b.id);
                    check("bresp", bresp, b.resp);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_bid", bid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
    endtask

    // All drive tasks are entered and left just after a rising edge.
    task automatic do_aw(input logic [1:0] id, input logic [19:0] addr, input logic [1:0] len,
                         input logic [2:0] size, input logic [1:0] btype);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = btype;
        awvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!awready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("awready_seen", awready, 1);
        @(posedge aclk);
        #1 awvalid = 1'b0;
        @(negedge aclk);
        check("aw_hs_awready", awready, 0);
        check("aw_hs_wready", wready, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_w(input logic [31:0] d, input logic last, input int gap);
        int n;
        repeat (gap) begin
            @(posedge aclk);
            #1;
        end
        wdata = d; wstrb = 4'hF; wlast = last; wvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!wready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("wready_seen", wready, 1);
        @(posedge aclk);
        #1 wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic wait_b(input logic [1:0] id, input logic [1:0] resp, input bit bp);
        int n;
        n = 0;
        @(negedge aclk);
        while (!bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("bvalid_seen", bvalid, 1);
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                check("bp_bvalid", bvalid, 1);
                check("bp_bid", bid, id);
                check("bp_bresp", bresp, resp);
                check("bp_awready", awready, 0);
                @(negedge aclk);
            end
            @(posedge aclk);
            #1 bready = 1'b1;
            @(negedge aclk);
        end
        @(posedge aclk);
        @(negedge aclk);
        check("b_hs_bvalid", bvalid, 0);
        check("b_hs_awready", awready, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic run_burst(input logic [1:0] id, input logic [19:0] addr, input logic [1:0] len,
                             input logic [2:0] size, input logic [1:0] btype, input int last_beat,
                             input bit we_exp, input logic [1:0] resp_exp, input bit bp,
                             input int gap_beat);
        for (int i = 0; i <= int'(len); i++) begin
            if (we_exp) wq.push_back('{v_addr[i], v_strb[i], v_data[i], (i == int'(len))});
        end
        bq.push_back('{id, resp_exp});
        if (bp) bready = 1'b0;
        do_aw(id, addr, len, size, btype);
        for (int i = 0; i <= int'(len); i++) begin
            do_w(v_data[i], (i == last_beat), (i == gap_beat) ? 3 : 0);
        end
        wait_b(id, resp_exp, bp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs();
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("awready_after_reset", awready, 1);
        @(posedge aclk);
        #1;

        // INCR, 4 word beats from 0x100, with a wait state before beat 1
        v_addr = '{18'h40, 18'h41, 18'h42, 18'h43};
        v_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        v_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_burst(2'd1, 20'h00100, 2'd3, 3'd2, BURST_INCR, 3, 1'b1, RESP_OKAY, 1'b0, 1);

        // WRAP, 16-byte window starting mid-window
        v_addr = '{18'h2, 18'h3, 18'h0, 18'h1};
        v_data = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
        run_burst(2'd2, 20'h00008, 2'd3, 3'd2, BURST_WRAP, 3, 1'b1, RESP_OKAY, 1'b0, -1);

        // FIXED byte beats at lane 3
        v_addr = '{18'h0, 18'h0, 18'h0, 18'h0};
        v_strb = '{4'b1000, 4'b1000, 4'h0, 4'h0};
        v_data = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0, 32'h0};
        run_burst(2'd3, 20'h00003, 2'd1, 3'd0, BURST_FIXED, 1, 1'b1, RESP_OKAY, 1'b0, -1);

        // Reserved burst type: 3 beats drained, no writes, SLVERR held under backpressure
        v_data = '{32'h5, 32'h6, 32'h7, 32'h0};
        run_burst(2'd0, 20'h00040, 2'd2, 3'd2, BURST_RSVD, 2, 1'b0, RESP_SLVERR, 1'b1, -1);

        // INCR with wlast early on beat 2: all 4 writes, SLVERR after beat 4
        v_addr = '{18'h80, 18'h81, 18'h82, 18'h83};
        v_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        v_data = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        run_burst(2'd2, 20'h00200, 2'd3, 3'd2, BURST_INCR, 1, 1'b1, RESP_SLVERR, 1'b0, -1);

        // Narrow INCR halfwords from 0x402: upper half then lower half of next word
        v_addr = '{18'h100, 18'h101, 18'h0, 18'h0};
        v_strb = '{4'b1100, 4'b0011, 4'h0, 4'h0};
        v_data = '{32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0};
        run_burst(2'd3, 20'h00402, 2'd1, 3'd1, BURST_INCR, 1, 1'b1, RESP_OKAY, 1'b0, -1);

        // Reset in the middle of DATA: two writes land, then the burst is abandoned
        wq.push_back('{18'h60, 4'hF, 32'hBBBB0000, 1'b0});
        wq.push_back('{18'h61, 4'hF, 32'hBBBB0001, 1'b0});
        do_aw(2'd1, 20'h00180, 2'd3, 3'd2, BURST_INCR);
        do_w(32'hBBBB0000, 1'b0, 0);
        do_w(32'hBBBB0001, 1'b0, 0);
        @(negedge aclk);
        @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs();
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("awready_release_edge", awready, 0);
        @(negedge aclk);
        check("awready_one_after_release", awready, 1);
        check("bvalid_after_reset", bvalid, 0);
        @(posedge aclk);
        #1;

        // Single beat at the top of the address space after recovery
        v_addr = '{18'h3FFFF, 18'h0, 18'h0, 18'h0};
        v_strb = '{4'hF, 4'h0, 4'h0, 4'h0};
        v_data = '{32'hFEEDFACE, 32'h0, 32'h0, 32'h0};
        run_burst(2'd1, 20'hFFFFC, 2'd0, 3'd2, BURST_INCR, 0, 1'b1, RESP_OKAY, 1'b0, -1);

        repeat (3) @(negedge aclk);
        check("writes_outstanding", wq.size(), 0);
        check("bresp_outstanding", bq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
